// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the front-panel key conditioner:
//   - key index constants (bit positions within the 5-bit key vectors)
//   - per-key FSM state encoding
//   - counter-width helper used by the prescaler and per-key counters
// No ports; imported by key_conditioner and key_channel.
// -----------------------------------------------------------------------------
package key_pkg;

  localparam int NUM_KEYS  = 5;
  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_UP    = 2;
  localparam int KEY_DOWN  = 3;
  localparam int KEY_APPLY = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_t;

  // Width of a counter that runs 0..max_val-1; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/key_channel.sv
// -----------------------------------------------------------------------------
// key_channel
// Conditioning for one key: debounce against the shared millisecond tick,
// then a press / auto-repeat state machine producing single-cycle strobes.
//
// Ports:
//   CP         in   system clock
//   _CR        in   synchronous active-high reset
//   ms_tick    in   one-cycle strobe, once per millisecond (shared)
//   synced     in   key input already synchronized to CP
//   key_level  out  debounced key level
//   key_pulse  out  one-cycle strobe on accepted press and on each repeat
// -----------------------------------------------------------------------------
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic CP,
  input  logic _CR,
  input  logic ms_tick,
  input  logic synced,
  output logic key_level,
  output logic key_pulse
);

  localparam int DB_W   = cnt_width(DEBOUNCE_MS);
  localparam int RP_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int RP_W   = cnt_width(RP_MAX);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_MS - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE_MS - 1);

  logic [DB_W-1:0] stab_cnt;
  logic [RP_W-1:0] rpt_cnt;
  key_state_t      state;
  logic            accept;
  logic            falling;

  // A level change is accepted on the tick where the stability count would
  // reach the debounce time. Seeing a falling acceptance one cycle early lets
  // the FSM drop a repeat strobe that lands on the same tick as the release.
  assign accept  = (synced != key_level) && ms_tick && (stab_cnt == DB_LAST);
  assign falling = accept && key_level;

  // Debounce: any cycle where the input agrees with the accepted level
  // restarts the stability window, so only an uninterrupted disagreement
  // lasting the full debounce time flips the level.
  always_ff @(posedge CP) begin
    if (_CR) begin
      stab_cnt  <= '0;
      key_level <= 1'b0;
    end else if (synced == key_level) begin
      stab_cnt <= '0;
    end else if (ms_tick) begin
      if (stab_cnt == DB_LAST) begin
        key_level <= ~key_level;
        stab_cnt  <= '0;
      end else begin
        stab_cnt <= stab_cnt + DB_W'(1);
      end
    end
  end

  // Press / repeat FSM. It reacts to the registered level, so the press strobe
  // appears the cycle after key_level rises. Keys without repeat enabled park
  // in HELD with the repeat counter idle until released.
  always_ff @(posedge CP) begin
    if (_CR) begin
      state     <= ST_IDLE;
      rpt_cnt   <= '0;
      key_pulse <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_level) begin
            state     <= ST_HELD;
            rpt_cnt   <= '0;
            key_pulse <= 1'b1;
          end
        end
        ST_HELD: begin
          if (!key_level || falling) begin
            state   <= ST_IDLE;
            rpt_cnt <= '0;
          end else if (REPEAT_EN && ms_tick) begin
            if (rpt_cnt == DELAY_LAST) begin
              state     <= ST_REPEAT;
              rpt_cnt   <= '0;
              key_pulse <= 1'b1;
            end else begin
              rpt_cnt <= rpt_cnt + RP_W'(1);
            end
          end
        end
        ST_REPEAT: begin
          if (!key_level || falling) begin
            state   <= ST_IDLE;
            rpt_cnt <= '0;
          end else if (ms_tick) begin
            if (rpt_cnt == RATE_LAST) begin
              rpt_cnt   <= '0;
              key_pulse <= 1'b1;
            end else begin
              rpt_cnt <= rpt_cnt + RP_W'(1);
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          rpt_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Front-panel button conditioner: synchronizes five asynchronous buttons,
// debounces them against a shared millisecond tick and generates press and
// auto-repeat strobes for the cursor/edit logic.
//
// Ports:
//   CP         in   system clock (CLK_HZ)
//   _CR        in   synchronous active-high reset
//   key_raw    in   [4:0] raw buttons: 0 left, 1 right, 2 up, 3 down, 4 apply
//   key_level  out  [4:0] debounced level per key
//   key_pulse  out  [4:0] one-cycle press/repeat strobe per key
//   any_key    out  OR of key_level
// -----------------------------------------------------------------------------
module key_conditioner
  import key_pkg::*;
#(
  parameter int                  CLK_HZ          = 100_000_000,
  parameter int                  DEBOUNCE_MS     = 20,
  parameter int                  REPEAT_DELAY_MS = 500,
  parameter int                  REPEAT_RATE_MS  = 100,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = 5'b01100
) (
  input  logic                CP,
  input  logic                _CR,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic                any_key
);

  localparam int PRESCALE = CLK_HZ / 1000;
  localparam int PS_W     = cnt_width(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [NUM_KEYS-1:0] sync_1;
  logic [NUM_KEYS-1:0] sync_2;
  logic [PS_W-1:0]     ps_cnt;
  logic                ms_tick;

  // Two-flop synchronizer; only sync_2 is used by the channels.
  always_ff @(posedge CP) begin
    if (_CR) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= key_raw;
      sync_2 <= sync_1;
    end
  end

  // Millisecond prescaler; the tick is the terminal count itself.
  assign ms_tick = (ps_cnt == PS_LAST);

  always_ff @(posedge CP) begin
    if (_CR) begin
      ps_cnt <= '0;
    end else if (ms_tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_MS     (DEBOUNCE_MS),
      .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
      .REPEAT_RATE_MS  (REPEAT_RATE_MS),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_channel (
      .CP        (CP),
      ._CR       (_CR),
      .ms_tick   (ms_tick),
      .synced    (sync_2[i]),
      .key_level (key_level[i]),
      .key_pulse (key_pulse[i])
    );
  end

  assign any_key = |key_level;

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, CP frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_MS, default 20, ms of stable input needed to accept a change.
REQ-003 SHALL have parameter REPEAT_DELAY_MS, default 500, ms held before the first auto-repeat.
REQ-004 SHALL have parameter REPEAT_RATE_MS, default 100, ms between subsequent auto-repeats.
REQ-005 SHALL have parameter REPEAT_MASK, default 5'b01100, per-key auto-repeat enable (up/down only).
REQ-006 SHALL have port CP  input  1  single system clock.
REQ-007 SHALL have port _CR  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port key_raw  input  5  asynchronous buttons: bit0 left, bit1 right, bit2 up, bit3 down, bit4 apply.
REQ-009 SHALL have port key_level  output  5  debounced level per key.
REQ-010 SHALL have port key_pulse  output  5  one-CP-cycle press/repeat strobe per key, consumed by the cursor/edit logic.
REQ-011 SHALL have port any_key  output  1  OR of key_level.

Function
REQ-012 SHALL pass each key_raw bit through a 2-flop synchronizer; synced value lags key_raw by 2 CP cycles.
REQ-013 SHALL generate ms_tick: prescaler counts 0..CLK_HZ/1000-1; ms_tick high for one cycle at terminal count, then wraps to 0.
REQ-014 SHALL, per key, hold a stability counter: cleared whenever synced == key_level; incremented on ms_tick while synced != key_level.
REQ-015 SHALL toggle key_level and clear the stability counter on the ms_tick where the counter would reach DEBOUNCE_MS.
REQ-016 SHALL assert key_pulse[i] for exactly one CP cycle, the cycle after key_level[i] rises 0->1; no pulse on release.
REQ-017 SHALL run per-key FSM: IDLE (level 0) -> HELD on rise; HELD -> REPEAT after REPEAT_DELAY_MS ms_ticks; REPEAT stays, pulsing every REPEAT_RATE_MS ms_ticks; any state -> IDLE when key_level falls.
REQ-018 SHALL emit one key_pulse cycle on HELD->REPEAT and on each REPEAT_RATE_MS expiry.
REQ-019 SHALL keep keys with REPEAT_MASK bit 0 in HELD until release (one pulse per press).
REQ-020 SHALL suppress a pending repeat pulse if release and repeat expiry coincide; release wins.
REQ-021 SHALL treat keys independently; simultaneous pulses on several bits in one cycle are legal.
REQ-022 SHALL discard glitches shorter than DEBOUNCE_MS-1 ms; level unchanged, no pulse.
REQ-023 SHALL saturate nothing: counter widths are $clog2 of their maxima; repeat counter cleared on every state entry.

Reset
REQ-024 SHALL, while _CR high at a CP edge, clear synchronizers, prescaler, all counters, key_level=0, key_pulse=0, any_key=0, all FSMs to IDLE.
REQ-025 SHALL treat a key held through reset release as a new press: accepted after DEBOUNCE_MS, one pulse.
REQ-026 SHALL abort any in-progress debounce or repeat on reset mid-operation with no pulse emitted.

Structure
REQ-027 SHALL place key index constants (KEY_LEFT..KEY_APPLY, NUM_KEYS=5) and FSM state encoding in shared package key_pkg.
REQ-028 SHALL implement per-key logic in sub-module key_channel, instantiated NUM_KEYS times, sharing one ms_tick.

Verification (bench: CLK_HZ=8000 -> ms_tick every 8 CP; DEBOUNCE_MS=4, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=3)
REQ-029 SHALL cover: up pressed clean -> key_level[2] rises on 4th ms_tick after synced rise; key_pulse[2] one cycle next CP.
REQ-030 SHALL cover: left pulsed 2 ms then released -> key_level and key_pulse stay 0.
REQ-031 SHALL cover: down held 20 ms -> pulses at press, +10 ms, +13 ms, +16 ms, +19 ms; none after release.
REQ-032 SHALL cover: apply held 20 ms -> exactly one key_pulse[4].
REQ-033 SHALL cover: left and right pressed same cycle -> key_pulse[1:0]=2'b11 in the same cycle; any_key=1.
REQ-034 SHALL cover: _CR asserted 3 cycles mid-REPEAT with up held -> outputs 0 immediately; one new pulse 4 ms after release of _CR.
